// File: rtl/gcd_pkg.sv
// Shared types, constants and the state-to-control decode for the GCD controller.
package gcd_pkg;

    localparam int GCD_W  = 7;
    localparam int GCD_CW = 8;

    localparam logic OP_SUB  = 1'b0;
    localparam logic OP_SWAP = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CMP,
        SWAP,
        SUB,
        DONE
    } gcd_state_t;

    typedef struct packed {
        logic a_sel;
        logic b_sel;
        logic ta_ld;
        logic tb_ld;
        logic op_sel;
        logic busy;
        logic done;
    } gcd_ctrl_t;

    // Moore output table: every control line is a pure function of the state.
    function automatic gcd_ctrl_t ctrl_decode(input gcd_state_t s);
        gcd_ctrl_t c;
        c = '0;
        case (s)
            LOAD: begin
                c.a_sel = 1'b1;
                c.b_sel = 1'b1;
                c.ta_ld = 1'b1;
                c.tb_ld = 1'b1;
                c.busy  = 1'b1;
            end
            CMP: begin
                c.busy = 1'b1;
            end
            SWAP: begin
                c.op_sel = OP_SWAP;
                c.ta_ld  = 1'b1;
                c.tb_ld  = 1'b1;
                c.busy   = 1'b1;
            end
            SUB: begin
                c.op_sel = OP_SUB;
                c.ta_ld  = 1'b1;
                c.busy   = 1'b1;
            end
            DONE: begin
                c.busy = 1'b1;
                c.done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gcd_ctrl.sv
// Control FSM for the subtractive Euclidean GCD datapath.
// Optional saturating step counter is built only when GCD_ITER_CNT_EN is defined.
module gcd_ctrl
    import gcd_pkg::*;
#(
    parameter int W  = GCD_W,
    parameter int CW = GCD_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  ta_q,
    input  logic [W-1:0]  tb_q,
    output logic          a_sel,
    output logic          b_sel,
    output logic          ta_ld,
    output logic          tb_ld,
    output logic          op_sel,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  gcd_out,
    output logic [CW-1:0] iter_cnt
);

    gcd_state_t   state_q, state_d;
    logic [W-1:0] gcd_q, gcd_d;
    gcd_ctrl_t    ctrl;
    logic         tb_zero;
    logic         ta_lt_tb;

    assign tb_zero  = (tb_q == '0);
    assign ta_lt_tb = (ta_q < tb_q);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        gcd_d   = gcd_q;
        ctrl    = ctrl_decode(state_q);
        case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: state_d = CMP;
            CMP: begin
                if (tb_zero) begin
                    state_d = DONE;
                    gcd_d   = ta_q;
                end else if (ta_lt_tb) begin
                    state_d = SWAP;
                end else begin
                    state_d = SUB;
                end
            end
            SWAP:    state_d = CMP;
            SUB:     state_d = CMP;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gcd_q   <= '0;
        end else begin
            state_q <= state_d;
            gcd_q   <= gcd_d;
        end
    end

    assign a_sel   = ctrl.a_sel;
    assign b_sel   = ctrl.b_sel;
    assign ta_ld   = ctrl.ta_ld;
    assign tb_ld   = ctrl.tb_ld;
    assign op_sel  = ctrl.op_sel;
    assign busy    = ctrl.busy;
    assign done    = ctrl.done;
    assign gcd_out = gcd_q;

`ifdef GCD_ITER_CNT_EN
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] iter_q, iter_d;

    // Count SUB/SWAP steps, saturating; publish the count on the CMP->DONE edge.
    always_comb begin
        cnt_d  = cnt_q;
        iter_d = iter_q;
        case (state_q)
            LOAD: cnt_d = '0;
            SWAP, SUB: begin
                if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
            end
            CMP: begin
                if (tb_zero) iter_d = cnt_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            iter_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            iter_q <= iter_d;
        end
    end

    assign iter_cnt = iter_q;
`else
    assign iter_cnt = '0;
`endif

endmodule

// File: tb/tb_gcd_ctrl.sv
// Self-checking bench for gcd_ctrl: a behavioural TA/TB datapath closes the loop,
// and an independent operand model predicts the control pattern every cycle.
module tb_gcd_ctrl;
    import gcd_pkg::*;

    localparam int W  = 7;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  ta_r, tb_r;
    logic [W-1:0]  ext_a, ext_b;
    logic          a_sel, b_sel, ta_ld, tb_ld, op_sel, busy, done;
    logic [W-1:0]  gcd_out;
    logic [CW-1:0] iter_cnt;

    gcd_ctrl #(.W(W), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ta_q     (ta_r),
        .tb_q     (tb_r),
        .a_sel    (a_sel),
        .b_sel    (b_sel),
        .ta_ld    (ta_ld),
        .tb_ld    (tb_ld),
        .op_sel   (op_sel),
        .busy     (busy),
        .done     (done),
        .gcd_out  (gcd_out),
        .iter_cnt (iter_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // TA/TB registers and their input muxes, driven by the controller outputs.
    always @(posedge clk) begin
        if (ta_ld) ta_r <= a_sel ? ext_a : (op_sel ? tb_r : ta_r - tb_r);
        if (tb_ld) tb_r <= b_sel ? ext_b : ta_r;
    end

    typedef enum int {M_IDLE, M_LOAD, M_CMP, M_SWAP, M_SUB, M_DONE} m_st_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] gcd;
        int           k;
        int           done_cyc;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [W-1:0]  prev_gcd;
    logic [CW-1:0] prev_k;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Expected {a_sel,b_sel,ta_ld,tb_ld,op_sel,busy,done} for each state.
    function automatic logic [6:0] exp_pat(input m_st_t s);
        case (s)
            M_LOAD:  return 7'b1111010;
            M_CMP:   return 7'b0000010;
            M_SWAP:  return 7'b0011110;
            M_SUB:   return 7'b0010010;
            M_DONE:  return 7'b0000011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [CW-1:0] k_eff(input int k);
`ifdef GCD_ITER_CNT_EN
        return CW'(k);
`else
        return CW'(0 * k);
`endif
    endfunction

    function automatic logic [6:0] dut_pat();
        return {a_sel, b_sel, ta_ld, tb_ld, op_sel, busy, done};
    endfunction

    // One run: start pulse before edge 0, then walk cycles 1.. against the operand model.
    // start is re-asserted during cycles hold_from..hold_to; abort_at stops the walk early.
    task automatic run_gcd(input vec_t v, input int hold_from, input int hold_to, input int abort_at);
        m_st_t        st;
        logic [W-1:0] m_a, m_b, tmp;
        int           c;
        int           dut_done_cyc;
        @(negedge clk);
        ext_a = v.a;
        ext_b = v.b;
        start = 1'b1;
        @(posedge clk);
        st = M_LOAD;
        c = 0;
        dut_done_cyc = -1;
        m_a = '0;
        m_b = '0;
        while (1) begin
            @(negedge clk);
            c++;
            start = (c >= hold_from && c <= hold_to);
            if (done === 1'b1 && dut_done_cyc < 0) dut_done_cyc = c;
            check($sformatf("ctrl(%0d,%0d) cyc%0d", v.a, v.b, c), 32'(dut_pat()), 32'(exp_pat(st)));
            if (st == M_DONE) begin
                check($sformatf("gcd(%0d,%0d)", v.a, v.b), 32'(gcd_out), 32'(v.gcd));
                check($sformatf("iter(%0d,%0d)", v.a, v.b), 32'(iter_cnt), 32'(k_eff(v.k)));
                check($sformatf("done_cyc(%0d,%0d)", v.a, v.b), 32'(dut_done_cyc), 32'(v.done_cyc));
                prev_gcd = v.gcd;
                prev_k   = k_eff(v.k);
                break;
            end
            check($sformatf("gcd_hold(%0d,%0d) cyc%0d", v.a, v.b, c), 32'(gcd_out), 32'(prev_gcd));
            check($sformatf("iter_hold(%0d,%0d) cyc%0d", v.a, v.b, c), 32'(iter_cnt), 32'(prev_k));
            if (c == abort_at) begin
                start = 1'b0;
                return;
            end
            if (c > 600) begin
                check("run_budget", 32'(c), 32'(v.done_cyc));
                start = 1'b0;
                return;
            end
            case (st)
                M_LOAD: begin
                    m_a = v.a;
                    m_b = v.b;
                    st  = M_CMP;
                end
                M_CMP: begin
                    if (m_b == '0)     st = M_DONE;
                    else if (m_a < m_b) st = M_SWAP;
                    else               st = M_SUB;
                end
                M_SWAP: begin
                    tmp = m_a;
                    m_a = m_b;
                    m_b = tmp;
                    st  = M_CMP;
                end
                M_SUB: begin
                    m_a = m_a - m_b;
                    st  = M_CMP;
                end
                default: st = M_IDLE;
            endcase
        end
        start = 1'b0;
        @(negedge clk);
        check($sformatf("idle_after(%0d,%0d)", v.a, v.b), 32'(dut_pat()), 32'(exp_pat(M_IDLE)));
        check($sformatf("gcd_kept(%0d,%0d)", v.a, v.b), 32'(gcd_out), 32'(v.gcd));
    endtask

    vec_t vecs[7];
    vec_t v84, v48, v50;

    initial begin
        vecs[0] = '{a: 7'd84,  b: 7'd36, gcd: 7'd12, k: 7,   done_cyc: 17};
        vecs[1] = '{a: 7'd13,  b: 7'd13, gcd: 7'd13, k: 2,   done_cyc: 7};
        vecs[2] = '{a: 7'd0,   b: 7'd0,  gcd: 7'd0,  k: 0,   done_cyc: 3};
        vecs[3] = '{a: 7'd0,   b: 7'd5,  gcd: 7'd5,  k: 1,   done_cyc: 5};
        // 127 SUBs take TA from 127 down to 0 (1>=1 still subtracts), then one SWAP.
        vecs[4] = '{a: 7'd127, b: 7'd1,  gcd: 7'd1,  k: 128, done_cyc: 259};
        vecs[5] = '{a: 7'd5,   b: 7'd0,  gcd: 7'd5,  k: 0,   done_cyc: 3};
        vecs[6] = '{a: 7'd48,  b: 7'd18, gcd: 7'd6,  k: 8,   done_cyc: 19};
        v84 = vecs[0];
        v48 = vecs[6];
        v50 = vecs[5];

        rst   = 1'b1;
        start = 1'b0;
        ext_a = '0;
        ext_b = '0;
        prev_gcd = '0;
        prev_k   = '0;
        #1;
        check("reset_ctrl", 32'(dut_pat()), 32'(0));
        check("reset_gcd", 32'(gcd_out), 32'(0));
        check("reset_iter", 32'(iter_cnt), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 32'(dut_pat()), 32'(0));

        for (int i = 0; i < 7; i++) run_gcd(vecs[i], -1, -1, -1);

        // start re-asserted mid-run must not disturb result or timing.
        run_gcd(v84, 4, 10, -1);

        // Asynchronous reset in cycle 8 of a run clears everything before the next edge.
        run_gcd(v84, -1, -1, 8);
        #2 rst = 1'b1;
        #1;
        check("midrun_rst_ctrl", 32'(dut_pat()), 32'(0));
        check("midrun_rst_gcd", 32'(gcd_out), 32'(0));
        check("midrun_rst_iter", 32'(iter_cnt), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        prev_gcd = '0;
        prev_k   = '0;
        @(negedge clk);
        check("idle_after_midrun_rst", 32'(dut_pat()), 32'(0));
        run_gcd(v48, -1, -1, -1);

        // start held high: DONE -> one IDLE cycle -> LOAD again.
        @(negedge clk);
        ext_a = v50.a;
        ext_b = v50.b;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            case (c)
                1, 5:    check($sformatf("b2b cyc%0d", c), 32'(dut_pat()), 32'(exp_pat(M_LOAD)));
                2, 6:    check($sformatf("b2b cyc%0d", c), 32'(dut_pat()), 32'(exp_pat(M_CMP)));
                3, 7:    check($sformatf("b2b cyc%0d", c), 32'(dut_pat()), 32'(exp_pat(M_DONE)));
                default: check($sformatf("b2b cyc%0d", c), 32'(dut_pat()), 32'(exp_pat(M_IDLE)));
            endcase
            if (c == 3 || c == 7) check($sformatf("b2b gcd cyc%0d", c), 32'(gcd_out), 32'(5));
            if (c == 5) start = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
